// File: rtl/tour_cmd_sequencer.sv
// Replays a solved knight's tour into cmd_proc as vertical/horizontal leg pairs,
// taking the command path away from the UART for the tour's duration.
module tour_cmd_sequencer #(
  parameter int         NUM_MOVES  = 24,
  parameter logic [3:0] OP_MOVE    = 4'h2,
  parameter logic [3:0] OP_FANFARE = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        usurp,
  output logic        mv_vert_or_horiz,
  output logic        tour_err
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, VERT, WAIT_V, HORIZ, WAIT_H} state_e;

  state_e      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic        usurp_q, usurp_d;
  logic        vh_q, vh_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] hleg_q, hleg_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        tour_err_q, tour_err_d;

  logic        legal;
  logic        dx_neg, dy_neg;
  logic [1:0]  dx_mag, dy_mag;
  logic [15:0] vleg, hleg;
  logic        load;

  // Move decode: one-hot knight move into signed (dx,dy) offsets
  always_comb begin
    legal  = 1'b1;
    dx_neg = 1'b0;
    dy_neg = 1'b0;
    dx_mag = 2'd0;
    dy_mag = 2'd0;
    case (move)
      8'h01: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'h02: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'h04: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      8'h08: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'h10: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'h20: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'h40: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'h80: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      default: legal = 1'b0;
    endcase
    vleg = {OP_MOVE,    dy_neg ? 8'h7F : 8'h00, 2'b00, dy_mag};
    hleg = {OP_FANFARE, dx_neg ? 8'h3F : 8'hBF, 2'b00, dx_mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mv_indx_q  <= 5'd0;
      usurp_q    <= 1'b0;
      vh_q       <= 1'b0;
      cmd_q      <= 16'h0000;
      hleg_q     <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      tour_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      usurp_q    <= usurp_d;
      vh_q       <= vh_d;
      cmd_q      <= cmd_d;
      hleg_q     <= hleg_d;
      cmd_rdy_q  <= cmd_rdy_d;
      tour_err_q <= tour_err_d;
    end
  end

  // FETCH gives TourLogic a cycle to look up the move after mv_indx advances
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    usurp_d    = usurp_q;
    vh_d       = vh_q;
    cmd_d      = cmd_q;
    hleg_d     = hleg_q;
    cmd_rdy_d  = cmd_rdy_q;
    tour_err_d = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE:   if (start_tour) load = 1'b1;
      FETCH:  load = 1'b1;
      VERT:   if (clr_cmd_rdy) begin
                cmd_rdy_d = 1'b0;
                state_d   = WAIT_V;
              end
      WAIT_V: if (send_resp) begin
                cmd_d     = hleg_q;
                cmd_rdy_d = 1'b1;
                vh_d      = 1'b1;
                state_d   = HORIZ;
              end
      HORIZ:  if (clr_cmd_rdy) begin
                cmd_rdy_d = 1'b0;
                state_d   = WAIT_H;
              end
      WAIT_H: if (send_resp) begin
                if (mv_indx_q == LAST_INDX) begin
                  mv_indx_d = 5'd0;
                  usurp_d   = 1'b0;
                  vh_d      = 1'b0;
                  state_d   = IDLE;
                end else begin
                  mv_indx_d = mv_indx_q + 5'd1;
                  state_d   = FETCH;
                end
              end
      default: state_d = IDLE;
    endcase
    if (load) begin
      if (legal) begin
        cmd_d     = vleg;
        hleg_d    = hleg;
        cmd_rdy_d = 1'b1;
        vh_d      = 1'b0;
        usurp_d   = 1'b1;
        state_d   = VERT;
      end else begin
        tour_err_d = 1'b1;
        cmd_rdy_d  = 1'b0;
        vh_d       = 1'b0;
        usurp_d    = 1'b0;
        mv_indx_d  = 5'd0;
        state_d    = IDLE;
      end
    end
  end

  always_comb begin
    mv_indx          = mv_indx_q;
    usurp            = usurp_q;
    mv_vert_or_horiz = vh_q;
    tour_err         = tour_err_q;
    if (usurp_q) begin
      cmd              = cmd_q;
      cmd_rdy          = cmd_rdy_q;
      clr_cmd_rdy_UART = 1'b0;
      resp = ((state_q == WAIT_H) && (mv_indx_q == LAST_INDX)) ? 8'hA5 : 8'h5A;
    end else begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
      resp             = 8'hA5;
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: a TourLogic lookup model feeds moves,
// and expected leg commands are queued up front and popped as cmd_rdy appears.
module tb_tour_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        usurp;
  logic        mv_vert_or_horiz;
  logic        tour_err;

  typedef struct packed {
    logic [15:0] cmd;
    logic [4:0]  idx;
    logic        vh;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tourTable [32];
  int         dxTab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int         dyTab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int         checks = 0;
  int         failures = 0;

  tour_cmd_sequencer dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .usurp(usurp), .mv_vert_or_horiz(mv_vert_or_horiz), .tour_err(tour_err)
  );

  always #5 clk = ~clk;

  // TourLogic stand-in: combinational lookup by index
  always_comb move = tourTable[mv_indx];

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushMoves(input int n);
    for (int i = 0; i < n; i++) begin
      int b, dx, dy;
      exp_t e;
      b = 0;
      for (int k = 0; k < 8; k++) if (tourTable[i][k]) b = k;
      dx = dxTab[b];
      dy = dyTab[b];
      e.cmd = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
      e.idx = 5'(i);
      e.vh  = 1'b0;
      sb.push_back(e);
      e.cmd = {4'h3, (dx < 0) ? 8'h3F : 8'hBF, 4'((dx < 0) ? -dx : dx)};
      e.vh  = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic startTour();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
  endtask

  task automatic waitCmdRdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (cmd_rdy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) checkVal("cmd_rdy_timeout", 16'(cmd_rdy), 16'h1);
  endtask

  task automatic handleLeg(input bit finalLeg);
    bit   ok;
    exp_t e;
    waitCmdRdy(ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 16'(sb.size()), 16'h1);
      return;
    end
    e = sb.pop_front();
    checkVal("leg_cmd", cmd, e.cmd);
    checkVal("leg_indx", 16'(mv_indx), 16'(e.idx));
    checkVal("leg_vh", 16'(mv_vert_or_horiz), 16'(e.vh));
    checkVal("leg_resp", 16'(resp), 16'h5A);
    clr_cmd_rdy = 1'b1;
    #1;
    checkVal("clr_uart_blocked", 16'(clr_cmd_rdy_UART), 16'h0);
    tick();
    clr_cmd_rdy = 1'b0;
    checkVal("cmd_rdy_dropped", 16'(cmd_rdy), 16'h0);
    checkVal("wait_resp", 16'(resp), finalLeg ? 16'hA5 : 16'h5A);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic applyStimulus();
    exp_t e;
    bit   ok;
    for (int i = 0; i < 32; i++) tourTable[i] = 8'h01 << (i % 8);
    tourTable[0] = 8'h01;
    tourTable[1] = 8'h04;
    tourTable[2] = 8'h20;

    rst = 1'b1; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'h0000; cmd_rdy_UART = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkVal("rst_cmd", cmd, 16'h0000);
    checkVal("rst_cmd_rdy", 16'(cmd_rdy), 16'h1);
    checkVal("rst_usurp", 16'(usurp), 16'h0);
    checkVal("rst_resp", 16'(resp), 16'hA5);
    checkVal("rst_indx", 16'(mv_indx), 16'h0);
    checkVal("rst_err", 16'(tour_err), 16'h0);
    clr_cmd_rdy = 1'b1;
    #1;
    checkVal("clr_passthru", 16'(clr_cmd_rdy_UART), 16'h1);
    clr_cmd_rdy = 1'b0;
    cmd_UART = 16'hC0DE;

    // Full tour, UART command left pending throughout
    pushMoves(24);
    startTour();
    checkVal("start_usurp", 16'(usurp), 16'h1);
    checkVal("start_cmd", cmd, 16'h2002);
    checkVal("start_cmd_rdy", 16'(cmd_rdy), 16'h1);
    checkVal("start_resp", 16'(resp), 16'h5A);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    checkVal("early_resp_ignored", 16'(cmd_rdy), 16'h1);
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin
        waitCmdRdy(ok);
        startTour();
        checkVal("start_ignored", 16'(mv_indx), 16'h3);
      end
      handleLeg(1'b0);
      handleLeg(i == 23);
    end
    checkVal("end_usurp", 16'(usurp), 16'h0);
    checkVal("end_indx", 16'(mv_indx), 16'h0);
    checkVal("end_cmd", cmd, 16'hC0DE);
    checkVal("end_pending_rdy", 16'(cmd_rdy), 16'h1);
    checkVal("end_resp", 16'(resp), 16'hA5);

    // Illegal move at index 5
    tourTable[5] = 8'h03;
    sb.delete();
    pushMoves(5);
    startTour();
    for (int i = 0; i < 5; i++) begin
      handleLeg(1'b0);
      handleLeg(1'b0);
    end
    checkVal("fetch_err_low", 16'(tour_err), 16'h0);
    checkVal("fetch_indx", 16'(mv_indx), 16'h5);
    tick();
    checkVal("err_pulse", 16'(tour_err), 16'h1);
    checkVal("err_usurp", 16'(usurp), 16'h0);
    checkVal("err_indx", 16'(mv_indx), 16'h0);
    tick();
    checkVal("err_one_cycle", 16'(tour_err), 16'h0);
    tourTable[5] = 8'h20;

    // Reset in HORIZ of index 7, then restart from index 0
    sb.delete();
    pushMoves(8);
    startTour();
    for (int i = 0; i < 7; i++) begin
      handleLeg(1'b0);
      handleLeg(1'b0);
    end
    handleLeg(1'b0);
    waitCmdRdy(ok);
    checkVal("horiz7_indx", 16'(mv_indx), 16'h7);
    checkVal("horiz7_vh", 16'(mv_vert_or_horiz), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("midrst_usurp", 16'(usurp), 16'h0);
    checkVal("midrst_indx", 16'(mv_indx), 16'h0);
    checkVal("midrst_vh", 16'(mv_vert_or_horiz), 16'h0);
    checkVal("midrst_err", 16'(tour_err), 16'h0);
    checkVal("midrst_cmd", cmd, 16'hC0DE);
    checkVal("midrst_resp", 16'(resp), 16'hA5);
    sb.delete();
    pushMoves(1);
    startTour();
    e = sb.pop_front();
    checkVal("restart_usurp", 16'(usurp), 16'h1);
    checkVal("restart_indx", 16'(mv_indx), 16'h0);
    checkVal("restart_cmd", cmd, e.cmd);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
